switch_input_port: RTL

Read-side peripheral for the TramelBlaze. It synchronizes and debounces 16 external switch inputs and tracks which bits changed. The processor reads the debounced switch value or the sticky change flags through a read-strobed input port. An interrupt request is raised on any debounced change and is cleared by the processor's interrupt acknowledge.

---
 rtl/switch_input_port_if.sv | 11 +
 rtl/switch_input_port.sv | 40 ++++
 2 files changed

// File: rtl/switch_input_port_if.sv
// switch_input_port_if: switch, read-port and interrupt signals between the TramelBlaze and the switch input port
interface switch_input_port_if #(parameter int WIDTH = 16);
  logic [WIDTH-1:0] sw_in;
  logic [WIDTH-1:0] D_out;
  logic             RD;
  logic             ADDR;
  logic             int_req;
  logic             int_ack;
  modport slave (input sw_in, RD, ADDR, int_ack, output D_out, int_req);
  modport master (output sw_in, RD, ADDR, int_ack, input D_out, int_req);
endinterface

// File: rtl/switch_input_port.sv
// switch_input_port: synchronized, debounced switch inputs with sticky change flags, read port and interrupt
module switch_input_port #(
  parameter int WIDTH    = 16,
  parameter int DB_COUNT = 500000,
  parameter int DB_W     = 19
) (
  input logic clock,
  input logic reset,
  switch_input_port_if.slave bus
);
  logic [WIDTH-1:0] s1, sync, sample_prev, debounced, flags, db_next, newset;
  logic [DB_W-1:0]  cnt;
  logic             tick;
  always_comb begin
    tick    = cnt == DB_W'(DB_COUNT - 1);
    db_next = tick ? (~(sync ^ sample_prev) & sync) | ((sync ^ sample_prev) & debounced) : debounced;
    newset  = db_next ^ debounced;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      s1          <= '0;
      sync        <= '0;
      sample_prev <= '0;
      debounced   <= '0;
      flags       <= '0;
      cnt         <= '0;
      bus.D_out   <= '0;
      bus.int_req <= 1'b0;
    end else begin
      s1          <= bus.sw_in;
      sync        <= s1;
      cnt         <= tick ? '0 : cnt + DB_W'(1);
      sample_prev <= tick ? sync : sample_prev;
      debounced   <= db_next;
      flags       <= bus.RD && bus.ADDR ? newset : flags | newset;
      bus.D_out   <= bus.RD ? (bus.ADDR ? flags : debounced) : bus.D_out;
      bus.int_req <= |newset | (bus.int_req & ~bus.int_ack);
    end
  end
endmodule
